// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides the fabric clock to a pixel tick and emits registered,
// mutually aligned x/y coordinates, sync pulses, active flag and per-pixel strobes.
module vga_timing_gen #(
   parameter int unsigned PIX_DIV   = 4,
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic        pix_valid,
   output logic        line_start,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 4096 || V_TOTAL > 4096 || PIX_DIV < 1) begin : g_param_check
      $error("vga_timing_gen: totals must be <= 4096 and PIX_DIV >= 1");
   end

   localparam int unsigned    DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);

   localparam logic [11:0] H_MAX = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_MAX = 12'(V_TOTAL - 1);
   // 13-bit window bounds: a window ending exactly at 4096 must not wrap to 0
   localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
   localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);

   logic [DIV_W-1:0] div_q, div_d;
   logic [11:0]      h_q, h_d, v_q, v_d;
   logic             tick;
   logic             hsync_d, vsync_d, active_d, line_start_d, frame_start_d;

   assign tick = (div_q == DIV_MAX);

   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (tick) begin
         if (h_q == H_MAX) begin
            h_d = '0;
            v_d = (v_q == V_MAX) ? 12'd0 : v_q + 12'd1;
         end else begin
            h_d = h_q + 12'd1;
         end
      end
   end

   always_comb begin
      hsync_d       = (({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END)) ? HSYNC_POL
                                                                          : ~HSYNC_POL;
      vsync_d       = (({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END)) ? VSYNC_POL
                                                                          : ~VSYNC_POL;
      active_d      = ({1'b0, h_d} < H_ACT) && ({1'b0, v_d} < V_ACT);
      line_start_d  = (h_d == 12'd0);
      frame_start_d = (h_d == 12'd0) && (v_d == 12'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         h_q   <= H_MAX;
         v_q   <= V_MAX;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   // Outputs load from the new h/v on the tick edge and hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         active      <= 1'b0;
         pix_valid   <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_valid   <= tick;
         line_start  <= tick & line_start_d;
         frame_start <= tick & frame_start_d;
         if (tick) begin
            x      <= h_d;
            y      <= v_d;
            hsync  <= hsync_d;
            vsync  <= vsync_d;
            active <= active_d;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised reset/run bench for vga_timing_gen on a small raster; expected pixels come from
// the tick index since reset release and are checked by an independent negedge monitor.
module tb_vga_timing_gen;

   localparam int unsigned PIX_DIV   = 3;
   localparam int unsigned H_ACTIVE  = 8;
   localparam int unsigned H_FP      = 2;
   localparam int unsigned H_SYNC    = 3;
   localparam int unsigned H_BP      = 2;
   localparam int unsigned V_ACTIVE  = 5;
   localparam int unsigned V_FP      = 1;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BP      = 1;
   localparam bit          HSYNC_POL = 1'b0;
   localparam bit          VSYNC_POL = 1'b1;
   localparam int unsigned HT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT        = V_ACTIVE + V_FP + V_SYNC + V_BP;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        hs;
      logic        vs;
      logic        act;
      logic        pv;
      logic        ls;
      logic        fs;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] x, y;
   logic        hsync, vsync, active, pix_valid, line_start, frame_start;

   int   total = 0;
   int   bad   = 0;
   obs_t exp_q[$];
   obs_t cur;
   obs_t rst_exp;

   vga_timing_gen #(
      .PIX_DIV(PIX_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .hsync(hsync), .vsync(vsync), .active(active),
      .pix_valid(pix_valid), .line_start(line_start), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Pixel number k after release maps to raster position k mod (HT*VT)
   function automatic obs_t model(int unsigned k);
      obs_t o;
      int unsigned p, px, py;
      p     = k % (HT * VT);
      px    = p % HT;
      py    = p / HT;
      o.x   = 12'(px);
      o.y   = 12'(py);
      o.hs  = (px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      o.vs  = (py >= V_ACTIVE + V_FP && py < V_ACTIVE + V_FP + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      o.act = (px < H_ACTIVE) && (py < V_ACTIVE);
      o.pv  = 1'b1;
      o.ls  = (px == 0);
      o.fs  = (p == 0);
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = '{x: x, y: y, hs: hsync, vs: vsync, act: active, pv: pix_valid, ls: line_start,
            fs: frame_start};
      return o;
   endfunction

   task automatic check(string name, obs_t got, obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b act=%b pv=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b act=%b pv=%b ls=%b fs=%b",
                  name, $time, got.x, got.y, got.hs, got.vs, got.act, got.pv, got.ls, got.fs,
                  want.x, want.y, want.hs, want.vs, want.act, want.pv, want.ls, want.fs);
      end
   endtask

   initial begin
      rst_exp = '{x: 12'd0, y: 12'd0, hs: ~HSYNC_POL, vs: ~VSYNC_POL, act: 1'b0, pv: 1'b0,
                  ls: 1'b0, fs: 1'b0};
      cur     = rst_exp;
   end

   // Monitor: consumes one expected pixel per pix_valid, otherwise expects held outputs
   always @(negedge clk) begin
      obs_t want;
      if (rst === 1'b1) begin
         cur = rst_exp;
         check("reset_hold", sample(), rst_exp);
      end else if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         cur  = want;
         check("pixel", sample(), want);
      end else begin
         want    = cur;
         want.pv = 1'b0;
         want.ls = 1'b0;
         want.fs = 1'b0;
         check("hold", sample(), want);
      end
   end

   initial begin
      int unsigned e;
      int unsigned len;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      for (int seg = 0; seg < 10; seg++) begin
         #3 rst = 1'b0;
         e   = 0;
         // First run covers a full frame wrap; later ones cut the frame at random points
         len = (seg == 0) ? 450 : $urandom_range(900, 5);
         for (int unsigned i = 0; i < len; i++) begin
            @(posedge clk);
            e++;
            if (e % PIX_DIV == 0) exp_q.push_back(model(e / PIX_DIV - 1));
         end
         #3 rst = 1'b1;
         exp_q.delete();
         #1 check("async_reset", sample(), rst_exp);
         repeat ($urandom_range(4, 1)) @(posedge clk);
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
